uart_cmd_master: RTL and testbench

Host-side initiator for the system's UART command protocol. It serialises one command frame per request into the UART TX parallel interface, then collects the response bytes returned by the system controller from the UART RX parallel interface. It sits on the host/test side of the UART link, across the wire from the system controller, and is also used as the in-system stimulus engine for link bring-up.

---
 rtl/uart_cmd_pkg.sv | 57 +++++
 rtl/uart_cmd_frame_mux.sv | 55 +++++
 rtl/uart_cmd_master.sv | 170 +++++++++++++++++
 tb/tb_uart_cmd_master.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared definitions for the UART command protocol.
// Opcodes, command encoding, master states, frame/response lengths.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WR  = 8'hAA;
  localparam logic [7:0] OP_RD  = 8'hBB;
  localparam logic [7:0] OP_ALU = 8'hCC;
  localparam logic [7:0] OP_NOP = 8'hDD;

  typedef enum logic [1:0] {
    CMD_WR  = 2'd0,
    CMD_RD  = 2'd1,
    CMD_ALU = 2'd2,
    CMD_NOP = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_DONE,
    S_RECV,
    S_DONE
  } state_e;

  localparam int FRAME_LEN_WR  = 3;
  localparam int FRAME_LEN_RD  = 2;
  localparam int FRAME_LEN_ALU = 4;
  localparam int FRAME_LEN_NOP = 2;

  localparam int RSP_LEN_WR  = 0;
  localparam int RSP_LEN_RD  = 1;
  localparam int RSP_LEN_ALU = 2;
  localparam int RSP_LEN_NOP = 2;

  function automatic logic [2:0] frame_len(cmd_e c);
    logic [2:0] n;
    unique case (c)
      CMD_WR:  n = 3'(FRAME_LEN_WR);
      CMD_RD:  n = 3'(FRAME_LEN_RD);
      CMD_ALU: n = 3'(FRAME_LEN_ALU);
      CMD_NOP: n = 3'(FRAME_LEN_NOP);
    endcase
    return n;
  endfunction

  function automatic logic [1:0] rsp_len(cmd_e c);
    logic [1:0] n;
    unique case (c)
      CMD_WR:  n = 2'(RSP_LEN_WR);
      CMD_RD:  n = 2'(RSP_LEN_RD);
      CMD_ALU: n = 2'(RSP_LEN_ALU);
      CMD_NOP: n = 2'(RSP_LEN_NOP);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_cmd_frame_mux.sv
// uart_cmd_frame_mux: picks the outgoing frame byte
// from the latched command fields and the byte index.
module uart_cmd_frame_mux
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  cmd_e                  cmd,
  input  logic [1:0]            idx,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic [3:0]            fun,
  output logic [DATA_WIDTH-1:0] tx_byte
);

  logic [DATA_WIDTH-1:0] op;
  logic [DATA_WIDTH-1:0] fun_ext;

  assign fun_ext = DATA_WIDTH'(fun);

  // Opcode byte for the latched command
  always_comb begin
    op = '0;
    unique case (cmd)
      CMD_WR:  op = DATA_WIDTH'(OP_WR);
      CMD_RD:  op = DATA_WIDTH'(OP_RD);
      CMD_ALU: op = DATA_WIDTH'(OP_ALU);
      CMD_NOP: op = DATA_WIDTH'(OP_NOP);
    endcase
  end

  // Byte selection by command and position in the frame
  always_comb begin
    tx_byte = op;
    unique case (cmd)
      CMD_WR: begin
        if (idx == 2'd1) tx_byte = addr;
        else if (idx == 2'd2) tx_byte = data_a;
      end
      CMD_RD: begin
        if (idx == 2'd1) tx_byte = addr;
      end
      CMD_ALU: begin
        if (idx == 2'd1) tx_byte = data_a;
        else if (idx == 2'd2) tx_byte = data_b;
        else if (idx == 2'd3) tx_byte = fun_ext;
      end
      CMD_NOP: begin
        if (idx == 2'd1) tx_byte = fun_ext;
      end
    endcase
  end

endmodule

// File: rtl/uart_cmd_master.sv
// uart_cmd_master: sends one command frame per request over UART TX,
// then gathers the response bytes from UART RX, with timeout abort.
module uart_cmd_master
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 4096
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ_VLD,
  output logic                    REQ_RDY,
  input  logic [1:0]              REQ_CMD,
  input  logic [DATA_WIDTH-1:0]   REQ_ADDR,
  input  logic [DATA_WIDTH-1:0]   REQ_DATA_A,
  input  logic [DATA_WIDTH-1:0]   REQ_DATA_B,
  input  logic [3:0]              REQ_FUN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    Busy,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic [2*DATA_WIDTH-1:0] RSP_DATA,
  output logic                    RSP_VLD,
  output logic                    RSP_ERR
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Abort on the edge where the timer would reach TIMEOUT-1
  localparam logic [TW-1:0] T_ABORT = TW'(TIMEOUT - 2);

  state_e                state;
  cmd_e                  cmd_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [3:0]            fun_q;
  logic [1:0]            idx;
  logic                  rx_cnt;
  logic [TW-1:0]         timer;
  logic [DATA_WIDTH-1:0] mux_byte;
  logic                  t_exp;
  logic                  last_tx;
  logic                  last_rx;

  assign t_exp   = (timer == T_ABORT);
  assign last_tx = ({1'b0, idx} == frame_len(cmd_q) - 3'd1);
  assign last_rx = rx_cnt || (rsp_len(cmd_q) == 2'd1);

  uart_cmd_frame_mux #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux (
    .cmd    (cmd_q),
    .idx    (idx),
    .addr   (addr_q),
    .data_a (a_q),
    .data_b (b_q),
    .fun    (fun_q),
    .tx_byte(mux_byte)
  );

  assign TX_P_DATA = TX_D_VLD ? mux_byte : '0;

  // Request FSM: frame transmit, response capture, timeout abort
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= S_IDLE;
      cmd_q    <= CMD_WR;
      addr_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      fun_q    <= '0;
      idx      <= '0;
      rx_cnt   <= 1'b0;
      timer    <= '0;
      TX_D_VLD <= 1'b0;
      RSP_DATA <= '0;
      RSP_VLD  <= 1'b0;
      RSP_ERR  <= 1'b0;
      REQ_RDY  <= 1'b0;
    end else begin
      RSP_VLD <= 1'b0;
      RSP_ERR <= 1'b0;
      unique case (state)
        S_IDLE: begin
          REQ_RDY <= 1'b1;
          timer   <= '0;
          if (REQ_VLD && REQ_RDY) begin
            cmd_q    <= cmd_e'(REQ_CMD);
            addr_q   <= REQ_ADDR;
            a_q      <= REQ_DATA_A;
            b_q      <= REQ_DATA_B;
            fun_q    <= REQ_FUN;
            idx      <= '0;
            rx_cnt   <= 1'b0;
            RSP_DATA <= '0;
            TX_D_VLD <= 1'b1;
            REQ_RDY  <= 1'b0;
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (Busy) begin
            TX_D_VLD <= 1'b0;
            timer    <= '0;
            state    <= S_WAIT_DONE;
          end else if (t_exp) begin
            TX_D_VLD <= 1'b0;
            timer    <= '0;
            RSP_VLD  <= 1'b1;
            RSP_ERR  <= 1'b1;
            state    <= S_DONE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!Busy) begin
            timer <= '0;
            if (!last_tx) begin
              idx      <= idx + 2'd1;
              TX_D_VLD <= 1'b1;
              state    <= S_SEND;
            end else if (cmd_q == CMD_WR) begin
              RSP_VLD <= 1'b1;
              state   <= S_DONE;
            end else begin
              state <= S_RECV;
            end
          end else if (t_exp) begin
            timer   <= '0;
            RSP_VLD <= 1'b1;
            RSP_ERR <= 1'b1;
            state   <= S_DONE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_RECV: begin
          if (RX_D_VLD) begin
            timer  <= '0;
            rx_cnt <= 1'b1;
            if (!rx_cnt)
              RSP_DATA[DATA_WIDTH-1:0] <= RX_P_DATA;
            else
              RSP_DATA[2*DATA_WIDTH-1:DATA_WIDTH] <= RX_P_DATA;
            if (last_rx) begin
              RSP_VLD <= 1'b1;
              state   <= S_DONE;
            end
          end else if (t_exp) begin
            timer   <= '0;
            RSP_VLD <= 1'b1;
            RSP_ERR <= 1'b1;
            state   <= S_DONE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_DONE: begin
          timer   <= '0;
          REQ_RDY <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_master.sv
// tb_uart_cmd_master: directed bench with a frame/response model,
// a UART TX busy model and a per-cycle output monitor.
module tb_uart_cmd_master;

  localparam int DW = 8;
  localparam int TO = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        REQ_VLD = 1'b0;
  logic        REQ_RDY;
  logic [1:0]  REQ_CMD = 2'd0;
  logic [7:0]  REQ_ADDR = 8'h00;
  logic [7:0]  REQ_DATA_A = 8'h00;
  logic [7:0]  REQ_DATA_B = 8'h00;
  logic [3:0]  REQ_FUN = 4'h0;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        Busy = 1'b0;
  logic [7:0]  RX_P_DATA = 8'h00;
  logic        RX_D_VLD = 1'b0;
  logic [15:0] RSP_DATA;
  logic        RSP_VLD;
  logic        RSP_ERR;

  typedef struct packed {
    logic [15:0] d;
    logic        e;
  } rsp_t;

  logic [7:0] exp_tx[$];
  logic [7:0] tx_log[$];
  rsp_t       exp_rsp[$];

  int errors = 0;
  int checks = 0;
  int busy_left = 0;
  int budget = -1;

  uart_cmd_master #(
    .DATA_WIDTH(DW),
    .TIMEOUT(TO)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .REQ_VLD(REQ_VLD),
    .REQ_RDY(REQ_RDY),
    .REQ_CMD(REQ_CMD),
    .REQ_ADDR(REQ_ADDR),
    .REQ_DATA_A(REQ_DATA_A),
    .REQ_DATA_B(REQ_DATA_B),
    .REQ_FUN(REQ_FUN),
    .TX_P_DATA(TX_P_DATA),
    .TX_D_VLD(TX_D_VLD),
    .Busy(Busy),
    .RX_P_DATA(RX_P_DATA),
    .RX_D_VLD(RX_D_VLD),
    .RSP_DATA(RSP_DATA),
    .RSP_VLD(RSP_VLD),
    .RSP_ERR(RSP_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Frame model: byte sequence each command must put on the wire
  function automatic void push_frame(input logic [1:0] c,
      input logic [7:0] ad, input logic [7:0] a,
      input logic [7:0] b, input logic [3:0] f);
    case (c)
      2'd0: begin
        exp_tx.push_back(8'hAA);
        exp_tx.push_back(ad);
        exp_tx.push_back(a);
      end
      2'd1: begin
        exp_tx.push_back(8'hBB);
        exp_tx.push_back(ad);
      end
      2'd2: begin
        exp_tx.push_back(8'hCC);
        exp_tx.push_back(a);
        exp_tx.push_back(b);
        exp_tx.push_back({4'h0, f});
      end
      default: begin
        exp_tx.push_back(8'hDD);
        exp_tx.push_back({4'h0, f});
      end
    endcase
  endfunction

  // Response model: n bytes delivered out of what the command needs
  function automatic rsp_t rsp_model(input logic [1:0] c,
      input logic [7:0] b0, input logic [7:0] b1, input int n);
    rsp_t r;
    int need;
    need = (c == 2'd0) ? 0 : ((c == 2'd1) ? 1 : 2);
    r.d = 16'h0000;
    for (int i = 0; i < need && i < n; i++)
      r.d = r.d | (16'((i == 0) ? b0 : b1) << (8 * i));
    r.e = (n < need);
    return r;
  endfunction

  // UART TX model: Busy high for 10 cycles per accepted byte
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (busy_left > 0)
        busy_left--;
      else if (TX_D_VLD && budget != 0) begin
        busy_left = 10;
        if (budget > 0) budget--;
      end
      Busy = (busy_left > 0);
    end
  end

  // Monitor: TX bytes and responses against the model queues
  initial begin
    rsp_t r;
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (!RSP_VLD) chk("rsp_err_idle", 32'(RSP_ERR), 32'd0);
        if (TX_D_VLD && Busy) begin
          tx_log.push_back(TX_P_DATA);
          if (exp_tx.size() == 0) fail_now("tx_unexpected");
          else chk("tx_byte", 32'(TX_P_DATA), 32'(exp_tx.pop_front()));
        end
        if (RSP_VLD) begin
          if (exp_rsp.size() == 0) fail_now("rsp_unexpected");
          else begin
            r = exp_rsp.pop_front();
            chk("rsp_data", 32'(RSP_DATA), 32'(r.d));
            chk("rsp_err", 32'(RSP_ERR), 32'(r.e));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_req(input logic [1:0] c, input logic [7:0] ad,
      input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    int n;
    n = 0;
    while (!REQ_RDY && n < 60) begin
      @(posedge CLK);
      #2;
      n++;
    end
    if (!REQ_RDY) fail_now("req_rdy_wait");
    REQ_CMD = c;
    REQ_ADDR = ad;
    REQ_DATA_A = a;
    REQ_DATA_B = b;
    REQ_FUN = f;
    REQ_VLD = 1'b1;
    @(posedge CLK);
    #2;
    REQ_VLD = 1'b0;
    REQ_CMD = ~c;
    REQ_ADDR = 8'hFF;
    REQ_DATA_A = 8'hEE;
    REQ_DATA_B = 8'hDD;
    REQ_FUN = 4'hF;
    chk("req_rdy_low", 32'(REQ_RDY), 32'd0);
    chk("tx_vld_first", 32'(TX_D_VLD), 32'd1);
  endtask

  task automatic wait_tx(input int target);
    int n;
    n = 0;
    while (!(tx_log.size() >= target && !Busy) && n < 400) begin
      @(posedge CLK);
      #2;
      n++;
    end
    if (tx_log.size() < target) fail_now("tx_bytes_wait");
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge CLK);
    #2;
    RX_P_DATA = b;
    RX_D_VLD = 1'b1;
    @(posedge CLK);
    #2;
    RX_D_VLD = 1'b0;
  endtask

  task automatic wait_rsp(output int k);
    k = 0;
    while (!RSP_VLD && k < 400) begin
      @(posedge CLK);
      #2;
      k++;
    end
    if (!RSP_VLD) fail_now("rsp_wait");
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"}, 32'(REQ_RDY), 32'd0);
    chk({tag, "_txv"}, 32'(TX_D_VLD), 32'd0);
    chk({tag, "_txd"}, 32'(TX_P_DATA), 32'd0);
    chk({tag, "_rspd"}, 32'(RSP_DATA), 32'd0);
    chk({tag, "_rspv"}, 32'(RSP_VLD), 32'd0);
    chk({tag, "_rspe"}, 32'(RSP_ERR), 32'd0);
  endtask

  initial begin
    int base;
    int k;
    repeat (2) @(posedge CLK);
    #2;
    chk_all_zero("reset");
    RST = 1'b1;
    @(posedge CLK);
    #2;
    chk("rdy_after_rst", 32'(REQ_RDY), 32'd1);

    // register write
    base = tx_log.size();
    push_frame(2'd0, 8'h05, 8'h3C, 8'h00, 4'h0);
    exp_rsp.push_back(rsp_model(2'd0, 8'h00, 8'h00, 0));
    do_req(2'd0, 8'h05, 8'h3C, 8'h00, 4'h0);
    wait_rsp(k);
    chk("wr_rsp_lit", 32'(RSP_DATA), 32'h0000);
    chk("wr_err_lit", 32'(RSP_ERR), 32'd0);
    chk("wr_b0", 32'(tx_log[base]), 32'hAA);
    chk("wr_b1", 32'(tx_log[base+1]), 32'h05);
    chk("wr_b2", 32'(tx_log[base+2]), 32'h3C);

    // register read
    base = tx_log.size();
    push_frame(2'd1, 8'h02, 8'h00, 8'h00, 4'h0);
    exp_rsp.push_back(rsp_model(2'd1, 8'h7E, 8'h00, 1));
    do_req(2'd1, 8'h02, 8'h00, 8'h00, 4'h0);
    wait_tx(base + 2);
    send_rx(8'h7E);
    chk("rd_vld_lat", 32'(RSP_VLD), 32'd1);
    chk("rd_data_lit", 32'(RSP_DATA), 32'h007E);
    chk("rd_rdy_busy", 32'(REQ_RDY), 32'd0);
    @(posedge CLK);
    #2;
    chk("rd_vld_pulse", 32'(RSP_VLD), 32'd0);
    chk("rd_rdy_back", 32'(REQ_RDY), 32'd1);

    // ALU with operands
    base = tx_log.size();
    push_frame(2'd2, 8'h00, 8'h12, 8'h34, 4'h2);
    exp_rsp.push_back(rsp_model(2'd2, 8'h48, 8'h03, 2));
    do_req(2'd2, 8'h00, 8'h12, 8'h34, 4'h2);
    wait_tx(base + 4);
    send_rx(8'h48);
    send_rx(8'h03);
    chk("alu_vld", 32'(RSP_VLD), 32'd1);
    chk("alu_data_lit", 32'(RSP_DATA), 32'h0348);
    chk("alu_fun_lit", 32'(tx_log[base+3]), 32'h02);

    // ALU without operands, stray RX byte while sending
    base = tx_log.size();
    push_frame(2'd3, 8'h00, 8'h00, 8'h00, 4'h1);
    exp_rsp.push_back(rsp_model(2'd3, 8'h5A, 8'hA5, 2));
    do_req(2'd3, 8'h00, 8'h00, 8'h00, 4'h1);
    RX_P_DATA = 8'h99;
    RX_D_VLD = 1'b1;
    @(posedge CLK);
    #2;
    RX_D_VLD = 1'b0;
    wait_tx(base + 2);
    send_rx(8'h5A);
    send_rx(8'hA5);
    chk("nop_vld", 32'(RSP_VLD), 32'd1);
    chk("nop_data_lit", 32'(RSP_DATA), 32'hA55A);

    // response timeout after one byte
    base = tx_log.size();
    push_frame(2'd2, 8'h00, 8'h01, 8'h02, 4'h3);
    exp_rsp.push_back(rsp_model(2'd2, 8'h11, 8'h00, 1));
    do_req(2'd2, 8'h00, 8'h01, 8'h02, 4'h3);
    wait_tx(base + 4);
    send_rx(8'h11);
    wait_rsp(k);
    chk("to_rx_cycles", 32'(k), 32'd15);
    chk("to_data_lit", 32'(RSP_DATA), 32'h0011);
    chk("to_err_lit", 32'(RSP_ERR), 32'd1);

    // Busy never rises
    budget = 0;
    exp_rsp.push_back(rsp_model(2'd1, 8'h00, 8'h00, 0));
    do_req(2'd1, 8'h07, 8'h00, 8'h00, 4'h0);
    wait_rsp(k);
    chk("stuck_cycles", 32'(k), 32'd15);
    chk("stuck_err_lit", 32'(RSP_ERR), 32'd1);
    budget = -1;

    // reset during the second byte of a write
    budget = 1;
    exp_tx.push_back(8'hAA);
    base = tx_log.size();
    do_req(2'd0, 8'h05, 8'h3C, 8'h00, 4'h0);
    k = 0;
    while (!(tx_log.size() == base + 1 && TX_D_VLD) && k < 100) begin
      @(posedge CLK);
      #2;
      k++;
    end
    if (k >= 100) fail_now("rst_wait_byte1");
    RST = 1'b0;
    @(posedge CLK);
    #2;
    chk_all_zero("midrst");
    budget = -1;
    @(posedge CLK);
    #2;
    RST = 1'b1;
    @(posedge CLK);
    #2;
    chk("rdy_after_midrst", 32'(REQ_RDY), 32'd1);
    base = tx_log.size();
    push_frame(2'd0, 8'h06, 8'h77, 8'h00, 4'h0);
    exp_rsp.push_back(rsp_model(2'd0, 8'h00, 8'h00, 0));
    do_req(2'd0, 8'h06, 8'h77, 8'h00, 4'h0);
    wait_rsp(k);
    chk("clean_b0", 32'(tx_log[base]), 32'hAA);
    chk("clean_b1", 32'(tx_log[base+1]), 32'h06);

    repeat (3) @(posedge CLK);
    #2;
    chk("exp_tx_left", 32'(exp_tx.size()), 32'd0);
    chk("exp_rsp_left", 32'(exp_rsp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
